// File: rtl/cam_pkg.sv
// Shared sizing and types for the CAM block: default geometry and the data/index/match types.
package cam_pkg;

  localparam int CAM_WIDTH_LOG2 = 5;
  localparam int CAM_SIZE_LOG2  = 5;
  localparam int DATA_W         = 2**CAM_WIDTH_LOG2;
  localparam int ENTRIES        = 2**CAM_SIZE_LOG2;

  typedef logic [DATA_W-1:0]        cam_data_t;
  typedef logic [CAM_SIZE_LOG2-1:0] cam_idx_t;
  typedef logic [ENTRIES-1:0]       cam_match_t;

endpackage

// File: rtl/cam_if.sv
// Request/response bundle between a CAM client (master) and the CAM itself (slave).
interface cam_if
  import cam_pkg::*;
#(
  parameter int ARRAY_WIDTH_LOG2 = CAM_WIDTH_LOG2,
  parameter int ARRAY_SIZE_LOG2  = CAM_SIZE_LOG2
) ();

  localparam int DW = 2**ARRAY_WIDTH_LOG2;
  localparam int SZ = ARRAY_SIZE_LOG2;

  logic          read_i;
  logic [SZ-1:0] read_index_i;
  logic          write_i;
  logic [SZ-1:0] write_index_i;
  logic [DW-1:0] write_data_i;
  logic          search_i;
  logic [DW-1:0] search_data_i;
  logic          read_valid_o;
  logic [DW-1:0] read_value_o;
  logic          search_valid_o;
  logic [SZ-1:0] search_index_o;

  modport master (
    output read_i, read_index_i,
    output write_i, write_index_i, write_data_i,
    output search_i, search_data_i,
    input  read_valid_o, read_value_o,
    input  search_valid_o, search_index_o
  );

  modport slave (
    input  read_i, read_index_i,
    input  write_i, write_index_i, write_data_i,
    input  search_i, search_data_i,
    output read_valid_o, read_value_o,
    output search_valid_o, search_index_o
  );

endinterface

// File: rtl/cam_priority_enc.sv
// Lowest-index-first priority encoder over the per-entry match vector; purely combinational.
module cam_priority_enc
  import cam_pkg::*;
#(
  parameter int ENTRIES_P = ENTRIES,
  parameter int IDX_W     = $clog2(ENTRIES_P)
) (
  input  logic [ENTRIES_P-1:0] match_i,
  output logic                 any_o,
  output logic [IDX_W-1:0]     idx_o
);

  // Scan from the top down so the last assignment made is the lowest set bit.
  always_comb begin
    any_o = |match_i;
    idx_o = '0;
    for (int k = ENTRIES_P - 1; k >= 0; k--) begin
      if (match_i[k]) begin
        idx_o = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/cam_array.sv
// Content-addressable memory with read-by-index, write-by-index and search-by-value, 1-cycle registered results.
module cam_array
  import cam_pkg::*;
#(
  parameter int ARRAY_WIDTH_LOG2 = CAM_WIDTH_LOG2,
  parameter int ARRAY_SIZE_LOG2  = CAM_SIZE_LOG2
) (
  input  logic clk,
  input  logic reset,
  cam_if.slave bus
);

  localparam int DW  = 2**ARRAY_WIDTH_LOG2;
  localparam int ENT = 2**ARRAY_SIZE_LOG2;
  localparam int SZ  = ARRAY_SIZE_LOG2;

  typedef logic [DW-1:0] data_t;
  typedef logic [SZ-1:0] idx_t;

  data_t          mem [ENT];
  logic [ENT-1:0] valid;
  logic [ENT-1:0] match;
  logic           hit_any;
  idx_t           hit_idx;
  logic           read_hit;

  assign read_hit = bus.read_i && valid[bus.read_index_i];

  // Match against the pre-write state; the write lands at the same edge the result is captured.
  always_comb begin
    match = '0;
    for (int k = 0; k < ENT; k++) begin
      match[k] = valid[k] && (mem[k] == bus.search_data_i);
    end
  end

  cam_priority_enc #(
    .ENTRIES_P (ENT),
    .IDX_W     (SZ)
  ) u_prio (
    .match_i (match),
    .any_o   (hit_any),
    .idx_o   (hit_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      for (int k = 0; k < ENT; k++) begin
        mem[k] <= '0;
      end
    end else if (bus.write_i) begin
      mem[bus.write_index_i]   <= bus.write_data_i;
      valid[bus.write_index_i] <= 1'b1;
    end
  end

  // Outputs fall back to zero whenever the matching request was absent or missed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.read_valid_o   <= 1'b0;
      bus.read_value_o   <= '0;
      bus.search_valid_o <= 1'b0;
      bus.search_index_o <= '0;
    end else begin
      bus.read_valid_o   <= read_hit;
      bus.read_value_o   <= read_hit ? mem[bus.read_index_i] : '0;
      bus.search_valid_o <= bus.search_i && hit_any;
      bus.search_index_o <= (bus.search_i && hit_any) ? hit_idx : '0;
    end
  end

endmodule
